// File: rtl/param_ram_ctrl.sv
// Single-port synchronous RAM that sweeps an init pattern into every word after each reset,
// with a 1-cycle registered read port and busy handshake. Optional parity: define RAM_PARITY_EN.
module param_ram_ctrl #(
  parameter int DATA_W    = 4,
  parameter int ADDR_W    = 4,
  parameter int INIT_MODE = 1,
  parameter int WR_FIRST  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
`ifdef RAM_PARITY_EN
  input  logic              err_inject,
  output logic              parity_err,
`endif
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              busy
);

  localparam int DEPTH = 2 ** ADDR_W;
`ifdef RAM_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int MEM_W = DATA_W + PAR_W;
  localparam int EXT_W = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;

  typedef enum logic {S_INIT, S_READY} state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_init_ptr, w_init_ptr_nxt;
  logic              w_mem_we, w_rd_en;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [MEM_W-1:0]  w_mem_din, w_rd_word;
  logic [MEM_W-1:0]  r_mem [DEPTH];
  logic [DATA_W-1:0] r_data_p1;
  logic              r_vld_p1;

  function automatic logic [DATA_W-1:0] init_val(input logic [ADDR_W-1:0] idx);
    logic [EXT_W-1:0] ext;
    ext = EXT_W'(idx);
    return (INIT_MODE != 0) ? ext[DATA_W-1:0] : '0;
  endfunction

  // Stored word layout: {even-parity bit (if enabled), data}.
  function automatic logic [MEM_W-1:0] pack_word(input logic [DATA_W-1:0] d);
`ifdef RAM_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_INIT;
      r_init_ptr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_init_ptr <= w_init_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_init_ptr_nxt = r_init_ptr;
    w_mem_we       = 1'b0;
    w_rd_en        = 1'b0;
    w_mem_addr     = addr;
    w_mem_din      = pack_word(data_in);
    if (r_state == S_INIT) begin
      w_mem_we       = 1'b1;
      w_mem_addr     = r_init_ptr;
      w_mem_din      = pack_word(init_val(r_init_ptr));
      w_init_ptr_nxt = r_init_ptr + ADDR_W'(1);
      if (r_init_ptr == '1) w_state_nxt = S_READY;
    end else begin
      w_mem_we = we;
      w_rd_en  = re;
`ifdef RAM_PARITY_EN
      w_mem_din = pack_word(data_in) ^ {err_inject, {DATA_W{1'b0}}};
`endif
    end
    // Memory is frozen while reset is held.
    if (rst) begin
      w_mem_we = 1'b0;
      w_rd_en  = 1'b0;
    end
  end

  assign w_rd_word = (w_mem_we && (WR_FIRST != 0)) ? w_mem_din : r_mem[addr];

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_mem_addr] <= w_mem_din;
  end

  // Stage p1: registered read data and valid
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1  <= 1'b0;
      r_data_p1 <= '0;
`ifdef RAM_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      r_vld_p1 <= w_rd_en;
      if (w_rd_en) r_data_p1 <= w_rd_word[DATA_W-1:0];
`ifdef RAM_PARITY_EN
      parity_err <= w_rd_en && (^w_rd_word);
`endif
    end
  end

  assign data_out = r_data_p1;
  assign rd_valid = r_vld_p1;
  assign busy     = (r_state == S_INIT);

endmodule

// File: tb/tb_param_ram_ctrl.sv
// Bench for param_ram_ctrl: two instances (INIT_MODE=1/WR_FIRST=1 and INIT_MODE=0/WR_FIRST=0)
// share stimulus; directed table, corner sequences and random traffic against an array model.
module tb_param_ram_ctrl;
  localparam int DW = 4;
  localparam int AW = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1, we = 1'b0, re = 1'b0, inj = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] din = '0;
  logic [DW-1:0] dout_a, dout_b;
  logic          vld_a, vld_b, busy_a, busy_b;
`ifdef RAM_PARITY_EN
  logic          perr_a, perr_b;
`endif

  param_ram_ctrl #(.DATA_W(DW), .ADDR_W(AW), .INIT_MODE(1), .WR_FIRST(1)) u_a (
    .clk(clk), .rst(rst), .we(we), .re(re), .addr(addr), .data_in(din),
`ifdef RAM_PARITY_EN
    .err_inject(inj), .parity_err(perr_a),
`endif
    .data_out(dout_a), .rd_valid(vld_a), .busy(busy_a));

  param_ram_ctrl #(.DATA_W(DW), .ADDR_W(AW), .INIT_MODE(0), .WR_FIRST(0)) u_b (
    .clk(clk), .rst(rst), .we(we), .re(re), .addr(addr), .data_in(din),
`ifdef RAM_PARITY_EN
    .err_inject(inj), .parity_err(perr_b),
`endif
    .data_out(dout_b), .rd_valid(vld_b), .busy(busy_b));

  int pass_cnt = 0;
  int chk_cnt = 0;

  logic [DW-1:0] m_a [DEPTH];
  logic [DW-1:0] m_b [DEPTH];
  int            busy_left = 0;
  logic [DW-1:0] e_dout_a = '0, e_dout_b = '0;
  bit            e_vld = 1'b0;
`ifdef RAM_PARITY_EN
  bit            bad_a [DEPTH];
  bit            bad_b [DEPTH];
  bit            e_perr_a = 1'b0, e_perr_b = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reset fills memory with the final pattern at once; the sweep itself is invisible
  // because requests are ignored until it has finished.
  task automatic model_edge();
    logic [DW-1:0] old_a, old_b;
    if (rst) begin
      busy_left = DEPTH;
      e_vld = 1'b0; e_dout_a = '0; e_dout_b = '0;
      for (int i = 0; i < DEPTH; i++) begin
        m_a[i] = DW'(i);
        m_b[i] = '0;
      end
`ifdef RAM_PARITY_EN
      e_perr_a = 1'b0; e_perr_b = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin bad_a[i] = 1'b0; bad_b[i] = 1'b0; end
`endif
    end else if (busy_left > 0) begin
      busy_left--;
      e_vld = 1'b0;
`ifdef RAM_PARITY_EN
      e_perr_a = 1'b0; e_perr_b = 1'b0;
`endif
    end else begin
      old_a = m_a[addr];
      old_b = m_b[addr];
      e_vld = re;
      if (re) begin
        e_dout_a = we ? din : old_a;
        e_dout_b = old_b;
      end
`ifdef RAM_PARITY_EN
      e_perr_a = re && (we ? inj : bad_a[addr]);
      e_perr_b = re && bad_b[addr];
      if (we) begin bad_a[addr] = inj; bad_b[addr] = inj; end
`endif
      if (we) begin
        m_a[addr] = din;
        m_b[addr] = din;
      end
    end
  endtask

  task automatic cyc(input bit w, input bit r, input int a, input int d, input bit rs, input bit ij);
    we = w; re = r; addr = AW'(a); din = DW'(d); rst = rs; inj = ij;
    @(posedge clk);
    model_edge();
    #1;
    chk("busy_a", {31'd0, busy_a}, {31'd0, busy_left > 0});
    chk("busy_b", {31'd0, busy_b}, {31'd0, busy_left > 0});
    chk("vld_a", {31'd0, vld_a}, {31'd0, e_vld});
    chk("vld_b", {31'd0, vld_b}, {31'd0, e_vld});
    chk("dout_a", {28'd0, dout_a}, {28'd0, e_dout_a});
    chk("dout_b", {28'd0, dout_b}, {28'd0, e_dout_b});
`ifdef RAM_PARITY_EN
    chk("perr_a", {31'd0, perr_a}, {31'd0, e_perr_a});
    chk("perr_b", {31'd0, perr_b}, {31'd0, e_perr_b});
`endif
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (busy_a === 1'b1 && n < 200) begin
      cyc(0, 0, 0, 0, 0, 0);
      n++;
    end
  endtask

  typedef struct {
    bit w; bit r; int a; int d;
    bit v; int ea; int eb;
  } vec_t;

  initial begin
    vec_t tbl [11];
    int n;

    tbl[0]  = '{0, 1, 4,  0, 1, 4,  0};
    tbl[1]  = '{1, 0, 5, 10, 0, 4,  0};
    tbl[2]  = '{0, 1, 5,  0, 1, 10, 10};
    tbl[3]  = '{0, 1, 4,  0, 1, 4,  0};
    tbl[4]  = '{1, 0, 3,  3, 0, 4,  0};
    tbl[5]  = '{1, 1, 3, 12, 1, 12, 3};
    tbl[6]  = '{0, 1, 3,  0, 1, 12, 12};
    tbl[7]  = '{0, 0, 0,  0, 0, 12, 12};
    tbl[8]  = '{0, 1, 15, 0, 1, 15, 0};
    tbl[9]  = '{1, 1, 0,  7, 1, 7,  0};
    tbl[10] = '{0, 1, 0,  0, 1, 7,  7};

    // Reset then full init sweep
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    chk("rst_busy", {31'd0, busy_a}, 32'd1);
    chk("rst_dout", {28'd0, dout_a}, 32'd0);
    wait_ready(n);
    chk("busy_len", n, 16);

    for (int i = 0; i < DEPTH; i++) begin
      cyc(0, 1, i, 0, 0, 0);
      chk($sformatf("rb_a[%0d]", i), {28'd0, dout_a}, i);
      chk($sformatf("rb_b[%0d]", i), {28'd0, dout_b}, 32'd0);
      chk($sformatf("rb_vld[%0d]", i), {31'd0, vld_a}, 32'd1);
    end

    for (int i = 0; i < 11; i++) begin
      cyc(tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].d, 0, 0);
      chk($sformatf("tbl_vld[%0d]", i), {31'd0, vld_a}, {31'd0, tbl[i].v});
      chk($sformatf("tbl_a[%0d]", i), {28'd0, dout_a}, tbl[i].ea);
      chk($sformatf("tbl_b[%0d]", i), {28'd0, dout_b}, tbl[i].eb);
    end

    // Reset in the middle of the sweep, with a write attempted while busy
    cyc(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 7; i++) cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(1, 0, 2, 9, 0, 0);
    wait_ready(n);
    chk("midinit_len", n + 1, 16);
    cyc(0, 1, 2, 0, 0, 0);
    chk("midinit_a2", {28'd0, dout_a}, 32'd2);
    chk("midinit_b2", {28'd0, dout_b}, 32'd0);

    // Reset after use restores the pattern
    cyc(1, 0, 0, 15, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    chk("pre_rst_a0", {28'd0, dout_a}, 32'd15);
    cyc(0, 0, 0, 0, 1, 0);
    wait_ready(n);
    chk("rerun_len", n, 16);
    cyc(0, 1, 0, 0, 0, 0);
    chk("post_rst_a0", {28'd0, dout_a}, 32'd0);
    chk("post_rst_b0", {28'd0, dout_b}, 32'd0);

`ifdef RAM_PARITY_EN
    cyc(1, 0, 6, 5, 0, 1);
    cyc(0, 1, 6, 0, 0, 0);
    chk("par_inj_data", {28'd0, dout_a}, 32'd5);
    chk("par_inj_err", {31'd0, perr_a}, 32'd1);
    cyc(1, 0, 6, 5, 0, 0);
    cyc(0, 1, 6, 0, 0, 0);
    chk("par_ok_err", {31'd0, perr_a}, 32'd0);
`endif

    // Random traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 15)),
          ($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0));
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/param_ram_ctrl.md
Name: param_ram_ctrl

Overview:
- Parametrised single-port synchronous RAM with a built-in power-up/reset initialisation sequencer and a registered read port with valid strobe.
- Generalises the lab 16x4 storage array in data width, address width and initial content pattern.
- Adds read-during-write policy selection and a busy/ready handshake.
- Used as the storage element under lab controllers and display front-ends that need known RAM content after every reset, not only at configuration time.

Parameters:
DATA_W, 4, data word width in bits (1..32)
ADDR_W, 4, address width; depth DEPTH = 2**ADDR_W words
INIT_MODE, 1, 0 = clear all words to zero; 1 = word[i] = i truncated or zero-extended to DATA_W
WR_FIRST, 1, 1 = same-address read during write returns new data; 0 = returns old data

Ports:
clk  input  1  system clock; all state changes on rising edge
rst  input  1  reset, synchronous, active-high
we  input  1  write enable; accepted only when busy=0
re  input  1  read enable; accepted only when busy=0
addr  input  ADDR_W  shared read/write address
data_in  input  DATA_W  write data
data_out  output  DATA_W  registered read data; holds its value between reads
rd_valid  output  1  one-cycle pulse, data_out updated this cycle
busy  output  1  1 while reset or the init sweep is active; all requests ignored

Behaviour:
- Reset (rst=1 on a clock edge): state <= INIT, init_ptr <= 0, busy <= 1, data_out <= 0, rd_valid <= 0. Memory contents are not touched while rst=1.
- FSM states: INIT, READY.
- INIT: each cycle with rst=0, write mem[init_ptr] <= init_val(init_ptr), then init_ptr++.
  - After writing address DEPTH-1: state <= READY and busy <= 0 on the same edge.
  - busy is therefore high for exactly DEPTH cycles after rst deasserts.
  - we and re are ignored; rd_valid stays 0.
- Reset mid-init: the sweep restarts from address 0. No partial-state carry-over.
- READY write: we=1 writes mem[addr] <= data_in on the edge.
- READY read: re=1 samples mem[addr] on the edge.
  - data_out is updated on that edge and rd_valid=1 for that one following cycle. Latency is 1 clock.
  - re=0 gives rd_valid=0 and data_out holds its value.
- Simultaneous we=1 and re=1, same address:
  - WR_FIRST=1: data_out = data_in.
  - WR_FIRST=0: data_out = previous mem[addr].
- Back-to-back reads every cycle are supported at full throughput.
- Address wrap-around: the full ADDR_W range is valid. There is no out-of-range condition.
- init_val: INIT_MODE=0 gives 0. INIT_MODE=1 gives the low DATA_W bits of the index, or the index zero-extended when DATA_W > ADDR_W.
- A reset while READY re-runs the init sweep, so memory returns to the init pattern after every reset.

Optional Feature:
- Macro RAM_PARITY_EN.
- Defined:
  - Each word stores one extra even-parity bit, computed from data_in on a write or from init_val during the sweep.
  - Extra ports: output parity_err (1 bit) and input err_inject (1 bit).
  - err_inject=1 during an accepted write stores the inverted parity bit.
  - On an accepted read, parity_err is registered alongside data_out and pulses with rd_valid when the stored parity mismatches the data. It is 0 otherwise and resets to 0.
- Undefined: no parity storage, and neither extra port exists.

Test Plan:
- Reset, INIT_MODE=1, DEPTH=16: rst high 2 cycles then low -> busy=1 for exactly 16 cycles then 0. Read addresses 0..15 return 0x0..0xF, each with a 1-cycle rd_valid pulse.
- Write with READY: we=1 addr=5 data_in=0xA, next cycle re=1 addr=5 -> data_out=0xA with rd_valid=1 one cycle later. Address 4 still reads 0x4.
- Same-address collision: mem[3]=0x3, then we=1 re=1 addr=3 data_in=0xC -> data_out=0xC with WR_FIRST=1, 0x3 with WR_FIRST=0. A following read returns 0xC in both cases.
- Reset mid-init: assert rst at sweep cycle 7, release -> busy lasts a full 16 cycles from release. we=1 addr=2 data_in=0x9 issued while busy is ignored; address 2 reads 0x2.
- Reset after use: write 0xF to addr 0, pulse rst, wait for busy=0 -> addr 0 reads 0x0. INIT_MODE=0 variant: all 16 addresses read 0x0.
- RAM_PARITY_EN: write addr 6 data_in=0x5 with err_inject=1, then read -> data_out=0x5 and parity_err=1. Rewrite with err_inject=0 and read -> parity_err=0.
